// File: rtl/pipe_ctrl_pkg.sv
// Shared decode definitions for the ID/EX control stage.
// Contents: opcode constants, ALU_op codes, REGDST/MTOR encodings,
// the packed control bundle ctrl_t and the all-zero CTRL_BUBBLE.
// Optional feature macro: ID_EX_CTRL_JUMP_EN (J/JAL decode, see main_ctrl_dec).
package pipe_ctrl_pkg;

  localparam int ALU_OP_BITS = 4;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_LUI   = 6'd15;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [ALU_OP_BITS-1:0] ALU_RTYPE = 4'd0;
  localparam logic [ALU_OP_BITS-1:0] ALU_BEQ   = 4'd2;
  localparam logic [ALU_OP_BITS-1:0] ALU_BNE   = 4'd3;
  localparam logic [ALU_OP_BITS-1:0] ALU_ADDI  = 4'd6;
  localparam logic [ALU_OP_BITS-1:0] ALU_ORI   = 4'd7;
  localparam logic [ALU_OP_BITS-1:0] ALU_LUI   = 4'd8;
  localparam logic [ALU_OP_BITS-1:0] ALU_LW    = 4'd9;
  localparam logic [ALU_OP_BITS-1:0] ALU_SW    = 4'd10;
  localparam logic [ALU_OP_BITS-1:0] ALU_SLTI  = 4'd11;

  localparam logic [1:0] REGDST_RT  = 2'd0;
  localparam logic [1:0] REGDST_RD  = 2'd1;
  localparam logic [1:0] REGDST_R31 = 2'd2;

  localparam logic [1:0] MTOR_ALU = 2'd0;
  localparam logic [1:0] MTOR_MEM = 2'd1;
  localparam logic [1:0] MTOR_PC4 = 2'd2;

  typedef struct packed {
    logic                   regwrite;
    logic                   alusrc;
    logic                   branch;
    logic                   memread;
    logic                   memwrite;
    logic                   jump;
    logic [ALU_OP_BITS-1:0] alu_op;
    logic [1:0]             regdst;
    logic [1:0]             memtoreg;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_ctrl_stage_if.sv
// Bus between IF/ID + hazard consumers and the ID/EX control stage.
// master: drives instr_i/id_valid_i/flush_i, observes everything else.
// slave : the stage; drives PC/IF-ID write enables, ID/EX register outputs
//         and the stall counter.
interface id_ex_ctrl_stage_if #(
  parameter int ALUOP_W = 4,
  parameter int RA_W    = 5,
  parameter int CNT_W   = 16
);
  logic [31:0]        instr_i;
  logic               id_valid_i;
  logic               flush_i;
  logic               pc_write_o;
  logic               ifid_write_o;
  logic               ex_valid_o;
  logic               ex_regwrite_o;
  logic               ex_alusrc_o;
  logic               ex_branch_o;
  logic               ex_memread_o;
  logic               ex_memwrite_o;
  logic               ex_jump_o;
  logic [ALUOP_W-1:0] ex_alu_op_o;
  logic [1:0]         ex_regdst_o;
  logic [1:0]         ex_memtoreg_o;
  logic [RA_W-1:0]    ex_rs_o;
  logic [RA_W-1:0]    ex_rt_o;
  logic [RA_W-1:0]    ex_rd_o;
  logic               ex_illegal_o;
  logic [CNT_W-1:0]   stall_cnt_o;

  modport master (
    output instr_i, id_valid_i, flush_i,
    input  pc_write_o, ifid_write_o, ex_valid_o, ex_regwrite_o, ex_alusrc_o,
           ex_branch_o, ex_memread_o, ex_memwrite_o, ex_jump_o, ex_alu_op_o,
           ex_regdst_o, ex_memtoreg_o, ex_rs_o, ex_rt_o, ex_rd_o,
           ex_illegal_o, stall_cnt_o
  );

  modport slave (
    input  instr_i, id_valid_i, flush_i,
    output pc_write_o, ifid_write_o, ex_valid_o, ex_regwrite_o, ex_alusrc_o,
           ex_branch_o, ex_memread_o, ex_memwrite_o, ex_jump_o, ex_alu_op_o,
           ex_regdst_o, ex_memtoreg_o, ex_rs_o, ex_rt_o, ex_rd_o,
           ex_illegal_o, stall_cnt_o
  );
endinterface

// File: rtl/main_ctrl_dec.sv
// Main control decoder: pure combinational opcode -> ctrl_t + illegal flag.
// Ports: i_op (6-bit opcode), o_ctrl (control bundle), o_illegal.
// Macro ID_EX_CTRL_JUMP_EN adds J/JAL decode; without it ops 2/3 are illegal.
// Unused fields are always 0 so nothing undefined leaves the decoder.
module main_ctrl_dec
  import pipe_ctrl_pkg::*;
(
  input  logic [5:0] i_op,
  output ctrl_t      o_ctrl,
  output logic       o_illegal
);

  always_comb begin
    o_ctrl    = CTRL_BUBBLE;
    o_illegal = 1'b0;
    case (i_op)
      OP_RTYPE: begin
        o_ctrl.alu_op   = ALU_RTYPE;
        o_ctrl.regwrite = 1'b1;
        o_ctrl.regdst   = REGDST_RD;
      end
      OP_BEQ: begin
        o_ctrl.alu_op = ALU_BEQ;
        o_ctrl.branch = 1'b1;
      end
      OP_BNE: begin
        o_ctrl.alu_op = ALU_BNE;
        o_ctrl.branch = 1'b1;
      end
      OP_ADDI, OP_SLTI, OP_ORI, OP_LUI: begin
        o_ctrl.alusrc   = 1'b1;
        o_ctrl.regwrite = 1'b1;
        o_ctrl.regdst   = REGDST_RT;
        case (i_op)
          OP_ADDI: o_ctrl.alu_op = ALU_ADDI;
          OP_SLTI: o_ctrl.alu_op = ALU_SLTI;
          OP_ORI:  o_ctrl.alu_op = ALU_ORI;
          default: o_ctrl.alu_op = ALU_LUI;
        endcase
      end
      OP_LW: begin
        o_ctrl.alu_op   = ALU_LW;
        o_ctrl.alusrc   = 1'b1;
        o_ctrl.regwrite = 1'b1;
        o_ctrl.regdst   = REGDST_RT;
        o_ctrl.memtoreg = MTOR_MEM;
        o_ctrl.memread  = 1'b1;
      end
      OP_SW: begin
        o_ctrl.alu_op   = ALU_SW;
        o_ctrl.alusrc   = 1'b1;
        o_ctrl.memwrite = 1'b1;
      end
`ifdef ID_EX_CTRL_JUMP_EN
      OP_J: begin
        o_ctrl.jump = 1'b1;
      end
      OP_JAL: begin
        o_ctrl.jump     = 1'b1;
        o_ctrl.regwrite = 1'b1;
        o_ctrl.regdst   = REGDST_R31;
        o_ctrl.memtoreg = MTOR_PC4;
        o_ctrl.alu_op   = ALU_RTYPE;
      end
`endif
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ex_ctrl_stage.sv
// ID/EX control stage: decodes the IF/ID instruction, detects load-use
// hazards, and registers the control bundle plus rs/rt/rd into ID/EX.
// Ports: clk_i, rst_i (async, active-low), bus (id_ex_ctrl_stage_if.slave):
//   in : instr_i, id_valid_i, flush_i
//   out: pc_write_o/ifid_write_o (comb), ex_* (registered), stall_cnt_o
// Macro ID_EX_CTRL_JUMP_EN enables J/JAL; by default ex_jump_o is tied 0.
module id_ex_ctrl_stage
  import pipe_ctrl_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 4,
  parameter int RA_W    = 5,
  parameter int CNT_W   = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  id_ex_ctrl_stage_if.slave  bus
);

  logic [OP_W-1:0]  w_op;
  logic [RA_W-1:0]  w_rs, w_rt, w_rd;
  ctrl_t            w_ctrl;
  logic             w_illegal;
  logic             w_hazard;

  ctrl_t            r_ctrl;
  logic             r_valid;
  logic             r_illegal;
  logic [RA_W-1:0]  r_rs, r_rt, r_rd;
  logic [CNT_W-1:0] r_stall_cnt;

  assign w_op = bus.instr_i[31 -: OP_W];
  assign w_rs = bus.instr_i[25 -: RA_W];
  assign w_rt = bus.instr_i[20 -: RA_W];
  assign w_rd = bus.instr_i[15 -: RA_W];

  main_ctrl_dec u_dec (
    .i_op      (w_op),
    .o_ctrl    (w_ctrl),
    .o_illegal (w_illegal)
  );

  // A load in EX whose destination is read in ID must wait one cycle;
  // $0 is never a real dependency.
  assign w_hazard = bus.id_valid_i & r_valid & r_ctrl.memread & (r_rt != '0) &
                    ((r_rt == w_rs) | (r_rt == w_rt));

  // A taken branch/jump squashes ID anyway, so fetch must not freeze.
  assign bus.pc_write_o   = ~(w_hazard & ~bus.flush_i);
  assign bus.ifid_write_o = ~(w_hazard & ~bus.flush_i);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ctrl      <= CTRL_BUBBLE;
      r_valid     <= 1'b0;
      r_illegal   <= 1'b0;
      r_rs        <= '0;
      r_rt        <= '0;
      r_rd        <= '0;
      r_stall_cnt <= '0;
    end else if (bus.flush_i || w_hazard || !bus.id_valid_i) begin
      r_ctrl    <= CTRL_BUBBLE;
      r_valid   <= 1'b0;
      r_illegal <= 1'b0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_rd      <= '0;
      // Only bubbles caused by a hazard (and not a flush) are counted.
      if (!bus.flush_i && w_hazard && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end else begin
      r_ctrl    <= w_ctrl;
      r_valid   <= 1'b1;
      r_illegal <= w_illegal;
      r_rs      <= w_rs;
      r_rt      <= w_rt;
      r_rd      <= w_rd;
    end
  end

  assign bus.ex_valid_o    = r_valid;
  assign bus.ex_regwrite_o = r_ctrl.regwrite;
  assign bus.ex_alusrc_o   = r_ctrl.alusrc;
  assign bus.ex_branch_o   = r_ctrl.branch;
  assign bus.ex_memread_o  = r_ctrl.memread;
  assign bus.ex_memwrite_o = r_ctrl.memwrite;
  // The decoder only sets jump when J/JAL decode is built in.
  assign bus.ex_jump_o     = r_ctrl.jump;
  assign bus.ex_alu_op_o   = ALUOP_W'(r_ctrl.alu_op);
  assign bus.ex_regdst_o   = r_ctrl.regdst;
  assign bus.ex_memtoreg_o = r_ctrl.memtoreg;
  assign bus.ex_rs_o       = r_rs;
  assign bus.ex_rt_o       = r_rt;
  assign bus.ex_rd_o       = r_rd;
  assign bus.ex_illegal_o  = r_illegal;
  assign bus.stall_cnt_o   = r_stall_cnt;

endmodule

// File: doc/id_ex_ctrl_stage.md
# id_ex_ctrl_stage

Registered decode stage for the pipelined MIPS core: decodes the opcode of the instruction in IF/ID, detects load-use hazards, and loads the control bundle plus register specifiers into the ID/EX pipeline register. It inserts bubbles on stall or flush and flags illegal opcodes instead of driving X. It sits between the IF/ID register and the EX stage and drives PC/IF-ID write enables.

## Interface
- OP_W, 6, opcode field width
- ALUOP_W, 4, ALU_op code width
- RA_W, 5, register specifier width
- CNT_W, 16, stall counter width
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- instr_i  in  32  IF/ID instruction; op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11]
- id_valid_i  in  1  IF/ID holds a real instruction
- flush_i  in  1  branch/jump resolved taken; squash ID
- pc_write_o  out  1  PC may advance (comb)
- ifid_write_o  out  1  IF/ID may load (comb)
- ex_valid_o  out  1  ID/EX holds a real instruction
- ex_regwrite_o, ex_alusrc_o, ex_branch_o, ex_memread_o, ex_memwrite_o, ex_jump_o  out  1 each  registered controls
- ex_alu_op_o  out  ALUOP_W  registered ALU op
- ex_regdst_o  out  2  0=rt, 1=rd, 2=r31
- ex_memtoreg_o  out  2  0=ALU, 1=MEM, 2=PC+4
- ex_rs_o, ex_rt_o, ex_rd_o  out  RA_W each  registered specifiers
- ex_illegal_o  out  1  registered illegal-opcode flag
- stall_cnt_o  out  CNT_W  saturating count of hazard bubbles

## Operation
- Decode map (op: alu_op, alusrc, regwrite/regdst, memtoreg, mem rd/wr, branch): 0 R-type: 0,0,1/1,0,00,0; 4 BEQ: 2,0,0,-,00,1; 5 BNE: 3,0,0,-,00,1; 8 ADDI: 6,1,1/0,0,00,0; 10 SLTI: 11,1,1/0,0,00,0; 13 ORI: 7,1,1/0,0,00,0; 15 LUI: 8,1,1/0,0,00,0; 35 LW: 9,1,1/0,1,10,0; 43 SW: 10,1,0,-,01,0.
- All don't-care fields driven 0; no X ever reaches outputs.
- Any other opcode: all controls 0, illegal=1, valid=1.
- Hazard = id_valid_i & ex_valid_o & ex_memread_o & ex_rt_o!=0 & (ex_rt_o==rs | ex_rt_o==rt).
- pc_write_o = ifid_write_o = ~(hazard & ~flush_i).
- ID/EX next-state priority: reset > flush_i (bubble) > hazard (bubble) > load decoded instruction with valid=id_valid_i.
- Bubble = valid 0, all controls 0, illegal 0, specifiers 0.
- id_valid_i=0: load bubble.
- stall_cnt_o increments on each hazard bubble not overridden by flush; holds at all-ones.

## Timing
- Reset: every registered output 0, stall_cnt_o 0; pc_write_o/ifid_write_o 1 (ex_valid_o=0). Reset asserted mid-stall discards the stall immediately (async).
- Decode-to-output latency 1 cycle.
- Load-use stall is exactly 1 cycle: the bubble clears ex_memread_o, so hazard drops and the held instruction loads next edge.
- flush_i and hazard in the same cycle: flush wins, pc_write_o=1, counter unchanged.
- Back-to-back LW then dependent LW: each dependent pair stalls 1 cycle independently.

## Configuration
- ID_EX_CTRL_JUMP_EN defined: op 2 J: jump=1, regwrite=0; op 3 JAL: jump=1, regwrite=1, regdst=2, memtoreg=2, alu_op=0.
- Undefined: ops 2 and 3 are illegal; ex_jump_o tied 0; regdst/memtoreg never take value 2.

## Structure
- Shared package pipe_ctrl_pkg: opcode constants, ALU_op codes, REGDST/MTOR encodings, packed ctrl_t struct and CTRL_BUBBLE constant.
- Sub-module main_ctrl_dec: pure combinational op -> ctrl_t + illegal; the stage instantiates it and owns hazard logic, register, counter.

## Test plan
- Reset release, no valid -> all ex_* 0, pc_write_o=1, stall_cnt_o=0.
- LW $8,0($1) then ADD $9,$8,$2 -> 1 bubble (ex_valid_o=0), pc_write_o=0 for 1 cycle, ADD appears next cycle with regdst=1, stall_cnt_o=1.
- LW $0 then ADD using $0 -> no stall.
- LW $8 then dependent ADD with flush_i=1 same cycle -> bubble, pc_write_o=1, stall_cnt_o unchanged.
- Op 6'd63 -> ex_illegal_o=1, all controls 0; op 3 -> JAL controls with macro, illegal without.
- Force 2^CNT_W+3 hazards (CNT_W=4 build) -> stall_cnt_o saturates at 15.
